csi2_pkt_enc: RTL and testbench

CSI-2 transmit-side packet framer. Accepts a packet descriptor (VC, data type, word count) and a 32-bit payload stream, and emits a framed 32-bit word stream: a header word with a 6-bit Hamming ECC, then for long packets the payload and a CRC-16 footer. It sits in the test-pattern and loopback TX path and drives the lane distributor. Its header ECC matches the parity equations of the RX header decoder bit-for-bit.

---
 rtl/csi2_pkg.sv | 42 ++++
 rtl/csi2_crc16_32.sv | 20 ++
 rtl/csi2_pkt_enc.sv | 157 +++++++++++++++
 tb/tb_csi2_pkt_enc.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2_pkg.sv
// rtl/csi2_pkg.sv - shared CSI-2 helpers: header ECC, CRC-16 byte step, FSM states
package csi2_pkg;

  localparam logic [5:0] CSI2_SHORT_DT_MAX = 6'h0F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PLD  = 2'd2,
    ST_FTR  = 2'd3
  } csi2_state_e;

  // Same parity equations the RX header decoder uses for its syndrome.
  function automatic logic [5:0] csi2_hdr_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^
           d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^
           d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^
           d[18] ^ d[20] ^ d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^
           d[19] ^ d[20] ^ d[21] ^ d[23];
    p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^
           d[19] ^ d[20] ^ d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^
           d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
    return p;
  endfunction

  // Reflected x^16+x^12+x^5+1, one byte, LSB first.
  function automatic logic [15:0] csi2_crc16_byte(input logic [15:0] crc,
                                                  input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/csi2_crc16_32.sv
// rtl/csi2_crc16_32.sv - combinational CRC-16 update over up to four strobed bytes
module csi2_crc16_32
  import csi2_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [31:0] data,
  input  logic [3:0]  strb,
  output logic [15:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        crc_out = csi2_crc16_byte(crc_out, data[8*i +: 8]);
      end
    end
  end

endmodule

// File: rtl/csi2_pkt_enc.sv
// rtl/csi2_pkt_enc.sv - CSI-2 TX packet framer: ECC header, payload, CRC-16 footer
module csi2_pkt_enc
  import csi2_pkg::*;
#(
  parameter logic CRC_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic        hdr_valid_i,
  output logic        hdr_ready_o,
  input  logic [1:0]  hdr_vc_i,
  input  logic [5:0]  hdr_dt_i,
  input  logic [15:0] hdr_wc_i,
  input  logic        pld_valid_i,
  output logic        pld_ready_o,
  input  logic [31:0] pld_data_i,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] tx_data_o,
  output logic [3:0]  tx_strb_o,
  output logic        tx_sop_o,
  output logic        tx_eop_o
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_HDR  = ST_HDR;
  localparam logic [1:0] S_PLD  = ST_PLD;
  localparam logic [1:0] S_FTR  = ST_FTR;

  logic [1:0]  state;
  logic [15:0] crc;
  logic [15:0] crc_upd;
  logic [15:0] rem;
  logic        pkt_short;

  logic        out_free;
  logic        hdr_fire;
  logic        pld_fire;
  logic        hdr_is_short;
  logic [23:0] hdr_d;
  logic [31:0] hdr_word;
  logic [3:0]  word_strb;
  logic [31:0] word_data;
  logic [15:0] rem_step;
  logic [15:0] ftr_crc;

  assign out_free     = !tx_valid_o || tx_ready_i;
  assign hdr_ready_o  = (state == S_IDLE) && out_free && !srst_i;
  assign pld_ready_o  = (state == S_PLD) && out_free && (rem != 16'd0);
  assign hdr_fire     = hdr_valid_i && hdr_ready_o;
  assign pld_fire     = pld_valid_i && pld_ready_o;

  assign hdr_d        = {hdr_wc_i, hdr_vc_i, hdr_dt_i};
  assign hdr_word     = {2'b00, csi2_hdr_ecc(hdr_d), hdr_d};
  assign hdr_is_short = (hdr_dt_i <= CSI2_SHORT_DT_MAX);
  assign ftr_crc      = CRC_EN ? crc : 16'hFFFF;

  // Fewer than four bytes left means this is the final, partial word.
  always_comb begin
    word_strb = 4'hF;
    rem_step  = 16'd4;
    if (rem < 16'd4) begin
      rem_step = rem;
      case (rem[1:0])
        2'd1:    word_strb = 4'b0001;
        2'd2:    word_strb = 4'b0011;
        2'd3:    word_strb = 4'b0111;
        default: word_strb = 4'b0000;
      endcase
    end
  end

  always_comb begin
    word_data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      word_data[8*i +: 8] = word_strb[i] ? pld_data_i[8*i +: 8] : 8'h00;
    end
  end

  csi2_crc16_32 u_crc (
    .crc_in  (crc),
    .data    (pld_data_i),
    .strb    (word_strb),
    .crc_out (crc_upd)
  );

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state      <= S_IDLE;
      crc        <= 16'hFFFF;
      rem        <= 16'd0;
      pkt_short  <= 1'b0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= 32'h0;
      tx_strb_o  <= 4'h0;
      tx_sop_o   <= 1'b0;
      tx_eop_o   <= 1'b0;
    end else begin
      // Output word consumed and nothing new loaded below: go empty.
      if (out_free) begin
        tx_valid_o <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (hdr_fire) begin
            crc        <= 16'hFFFF;
            rem        <= hdr_is_short ? 16'd0 : hdr_wc_i;
            pkt_short  <= hdr_is_short;
            tx_valid_o <= 1'b1;
            tx_data_o  <= hdr_word;
            tx_strb_o  <= 4'hF;
            tx_sop_o   <= 1'b1;
            tx_eop_o   <= hdr_is_short;
            state      <= S_HDR;
          end
        end
        S_HDR: begin
          if (out_free) begin
            if (pkt_short) begin
              state <= S_IDLE;
            end else if (rem != 16'd0) begin
              state <= S_PLD;
            end else begin
              state <= S_FTR;
            end
          end
        end
        S_PLD: begin
          if (pld_fire) begin
            crc        <= crc_upd;
            rem        <= rem - rem_step;
            tx_valid_o <= 1'b1;
            tx_data_o  <= word_data;
            tx_strb_o  <= word_strb;
            tx_sop_o   <= 1'b0;
            tx_eop_o   <= 1'b0;
            if (rem <= 16'd4) begin
              state <= S_FTR;
            end
          end
        end
        S_FTR: begin
          if (out_free) begin
            tx_valid_o <= 1'b1;
            tx_data_o  <= {16'h0000, ftr_crc};
            tx_strb_o  <= 4'b0011;
            tx_sop_o   <= 1'b0;
            tx_eop_o   <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csi2_pkt_enc.sv
// tb/tb_csi2_pkt_enc.sv - self-checking bench for csi2_pkt_enc
module tb_csi2_pkt_enc;

  logic        clk = 1'b0;
  logic        srst;
  logic        hdr_valid, hdr_ready;
  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic        pld_valid, pld_ready;
  logic [31:0] pld_data;
  logic        tx_valid, tx_ready;
  logic [31:0] tx_data;
  logic [3:0]  tx_strb;
  logic        tx_sop, tx_eop;

  always #5 clk = ~clk;

  csi2_pkt_enc #(.CRC_EN(1'b1)) dut (
    .clk_i       (clk),
    .srst_i      (srst),
    .hdr_valid_i (hdr_valid),
    .hdr_ready_o (hdr_ready),
    .hdr_vc_i    (hdr_vc),
    .hdr_dt_i    (hdr_dt),
    .hdr_wc_i    (hdr_wc),
    .pld_valid_i (pld_valid),
    .pld_ready_o (pld_ready),
    .pld_data_i  (pld_data),
    .tx_valid_o  (tx_valid),
    .tx_ready_i  (tx_ready),
    .tx_data_o   (tx_data),
    .tx_strb_o   (tx_strb),
    .tx_sop_o    (tx_sop),
    .tx_eop_o    (tx_eop)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic        sop;
    logic        eop;
  } w_t;

  typedef struct {
    logic [1:0]   vc;
    logic [5:0]   dt;
    logic [15:0]  wc;
    logic [191:0] pb;
    int           nwords;
    bit           hdr_k;
    logic [31:0]  hdr;
    bit           ftr_k;
    logic [31:0]  ftr;
  } vec_t;

  w_t   got_q[$];
  w_t   exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;
  bit   pld_stall = 1'b0;
  vec_t vecs[8];

  int ecc_bits [6][14] = '{
    '{0, 1, 2, 4, 5, 7, 10, 11, 13, 16, 20, 21, 22, 23},
    '{0, 1, 3, 4, 6, 8, 10, 12, 14, 17, 20, 21, 22, 23},
    '{0, 2, 3, 5, 6, 9, 11, 12, 15, 18, 20, 21, 22, -1},
    '{1, 2, 3, 7, 8, 9, 13, 14, 15, 19, 20, 21, 23, -1},
    '{4, 5, 6, 7, 8, 9, 16, 17, 18, 19, 20, 22, 23, -1},
    '{10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 21, 22, 23, -1}
  };

  function automatic logic [5:0] ref_ecc(input logic [23:0] d);
    logic [5:0] e;
    e = 6'h0;
    for (int p = 0; p < 6; p++)
      for (int k = 0; k < 14; k++)
        if (ecc_bits[p][k] >= 0) e[p] = e[p] ^ d[ecc_bits[p][k]];
    return e;
  endfunction

  function automatic logic [15:0] ref_crc(input logic [7:0] b[$], input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_pkt(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                           input logic [7:0] b[$]);
    logic [23:0] d;
    logic [31:0] w;
    logic [3:0]  s;
    bit          shrt;
    int          n;
    d    = {wc, vc, dt};
    shrt = (dt < 6'h10);
    exp_q.push_back({2'b00, ref_ecc(d), d, 4'hF, 1'b1, shrt});
    if (!shrt) begin
      n = int'(wc);
      for (int i = 0; i < n; i += 4) begin
        w = 32'h0;
        s = 4'h0;
        for (int k = 0; k < 4; k++)
          if (i + k < n) begin
            w[8*k +: 8] = b[i+k];
            s[k] = 1'b1;
          end
        exp_q.push_back({w, s, 1'b0, 1'b0});
      end
      exp_q.push_back({16'h0000, ref_crc(b, n), 4'b0011, 1'b0, 1'b1});
    end
  endtask

  task automatic send_pkt(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                          input logic [7:0] b[$]);
    int nw;
    int t;
    model_pkt(vc, dt, wc, b);
    hdr_vc = vc; hdr_dt = dt; hdr_wc = wc; hdr_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk); t++;
      if (srst) begin hdr_valid = 1'b0; return; end
    end while (!hdr_ready && t < 1000);
    if (!hdr_ready) begin
      chk("hdr_handshake_timeout", 64'(hdr_ready), 64'd1);
      hdr_valid = 1'b0;
      return;
    end
    @(posedge clk); #1 hdr_valid = 1'b0;
    nw = (dt < 6'h10) ? 0 : (int'(wc) + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      if (pld_stall) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      for (int k = 0; k < 4; k++) pld_data[8*k +: 8] = b[4*i+k];
      pld_valid = 1'b1;
      t = 0;
      do begin
        @(negedge clk); t++;
        if (srst) begin pld_valid = 1'b0; return; end
      end while (!pld_ready && t < 1000);
      if (!pld_ready) begin
        chk("pld_handshake_timeout", 64'(pld_ready), 64'd1);
        pld_valid = 1'b0;
        return;
      end
      @(posedge clk); #1 pld_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 20000) begin @(posedge clk); t++; end
    repeat (3) @(posedge clk);
    #1;
    chk("word_count", 64'(got_q.size()), 64'(exp_q.size()));
  endtask

  task automatic compare_words(input string tag);
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
      if (got_q[i].sop) begin
        chk($sformatf("%s_ecc_syndrome%0d", tag, i),
            64'(got_q[i].d[29:24] ^ ref_ecc(got_q[i].d[23:0])), 64'd0);
        chk($sformatf("%s_hdr_rsvd%0d", tag, i), 64'(got_q[i].d[31:30]), 64'd0);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic rand_pkt();
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic [7:0]  b[$];
    int          nw;
    vc = 2'($urandom);
    dt = 6'($urandom);
    if (dt < 6'h10) begin
      wc = 16'($urandom);
      nw = 0;
    end else begin
      wc = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom_range(0, 40));
      nw = (int'(wc) + 3) / 4;
    end
    for (int i = 0; i < 4 * nw; i++) b.push_back(8'($urandom));
    send_pkt(vc, dt, wc, b);
  endtask

  always @(negedge clk)
    if (!srst && tx_valid && tx_ready) got_q.push_back({tx_data, tx_strb, tx_sop, tx_eop});

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ($urandom_range(0, 3) != 0);
        default: tx_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b[$];
    int         nw;
    int         t;
    int         eops;

    vecs[0] = '{2'd0, 6'h01, 16'd0,  192'd0, 1, 1'b1, 32'h07000001, 1'b0, 32'h0};
    vecs[1] = '{2'd0, 6'h00, 16'd1,  192'd0, 1, 1'b1, 32'h1A000100, 1'b0, 32'h0};
    vecs[2] = '{2'd0, 6'h2B, 16'd24, 192'h010000FFDF05F8817CC275C85AB8D4BB72F3DCB9020000FF,
                8, 1'b0, 32'h0, 1'b1, 32'h000000F0};
    vecs[3] = '{2'd0, 6'h2B, 16'd24, 192'h010000FFE9783CD2708CE082C578824FC71EF01E000000FF,
                8, 1'b0, 32'h0, 1'b1, 32'h0000E569};
    vecs[4] = '{2'd1, 6'h2A, 16'd5,  192'hFEDCBA9876543210, 4, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[5] = '{2'd2, 6'h2C, 16'd0,  192'd0, 2, 1'b0, 32'h0, 1'b1, 32'h0000FFFF};
    vecs[6] = '{2'd3, 6'h0F, 16'hABCD, 192'd0, 1, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[7] = '{2'd0, 6'h10, 16'd3,  192'hDEADBEEF, 3, 1'b0, 32'h0, 1'b0, 32'h0};

    srst = 1'b1; hdr_valid = 1'b0; hdr_vc = 2'd0; hdr_dt = 6'd0; hdr_wc = 16'd0;
    pld_valid = 1'b0; pld_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_sop", 64'(tx_sop), 64'd0);
    chk("rst_tx_eop", 64'(tx_eop), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_tx_strb", 64'(tx_strb), 64'd0);
    chk("rst_hdr_ready", 64'(hdr_ready), 64'd0);
    chk("rst_pld_ready", 64'(pld_ready), 64'd0);
    srst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_hdr_ready", 64'(hdr_ready), 64'd1);

    for (int v = 0; v < 8; v++) begin
      b.delete();
      nw = (vecs[v].dt < 6'h10) ? 0 : (int'(vecs[v].wc) + 3) / 4;
      for (int i = 0; i < 4 * nw; i++) b.push_back(vecs[v].pb[8*i +: 8]);
      send_pkt(vecs[v].vc, vecs[v].dt, vecs[v].wc, b);
      drain();
      chk($sformatf("vec%0d_nwords", v), 64'(got_q.size()), 64'(vecs[v].nwords));
      if (vecs[v].hdr_k && got_q.size() > 0)
        chk($sformatf("vec%0d_hdr", v), 64'(got_q[0].d), 64'(vecs[v].hdr));
      if (vecs[v].ftr_k && got_q.size() > 0)
        chk($sformatf("vec%0d_ftr", v), 64'(got_q[got_q.size()-1].d), 64'(vecs[v].ftr));
      compare_words($sformatf("vec%0d", v));
    end

    // Header latency and hold-under-backpressure.
    ready_mode = 2;
    @(posedge clk); #1;
    b.delete();
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
    fork
      send_pkt(2'd0, 6'h2A, 16'd8, b);
      begin
        t = 0;
        do begin @(negedge clk); t++; end while (!(hdr_valid && hdr_ready) && t < 100);
        @(posedge clk); #1;
        chk("hdr_latency_valid", 64'(tx_valid), 64'd1);
        chk("hdr_latency_sop", 64'(tx_sop), 64'd1);
        chk("hdr_latency_data", 64'(tx_data), 64'(exp_q[0].d));
        chk("pld_ready_while_hdr", 64'(pld_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_valid", 64'(tx_valid), 64'd1);
        chk("hold_data", 64'(tx_data), 64'(exp_q[0].d));
        ready_mode = 0;
      end
    join
    drain();
    compare_words("hold");

    // Reset in the middle of a payload.
    b.delete();
    for (int i = 0; i < 40; i++) b.push_back(8'($urandom));
    fork
      send_pkt(2'd1, 6'h2B, 16'd40, b);
      begin
        t = 0;
        while (got_q.size() < 3 && t < 200) begin @(posedge clk); t++; end
        #2 srst = 1'b1;
        #1;
        chk("midrst_tx_valid", 64'(tx_valid), 64'd0);
        chk("midrst_hdr_ready", 64'(hdr_ready), 64'd0);
        chk("midrst_pld_ready", 64'(pld_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1 srst = 1'b0;
      end
    join
    eops = 0;
    foreach (got_q[i]) if (got_q[i].eop) eops++;
    chk("midrst_no_eop", 64'(eops), 64'd0);
    got_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    b.delete();
    for (int i = 0; i < 24; i++) b.push_back(vecs[2].pb[8*i +: 8]);
    send_pkt(vecs[2].vc, vecs[2].dt, vecs[2].wc, b);
    drain();
    if (got_q.size() > 0)
      chk("after_rst_ftr", 64'(got_q[got_q.size()-1].d), 64'h000000F0);
    compare_words("after_rst");

    // Random packets, no stalls, then with backpressure on both sides.
    for (int p = 0; p < 200; p++) rand_pkt();
    drain();
    compare_words("rand_nostall");

    ready_mode = 1;
    pld_stall  = 1'b1;
    for (int p = 0; p < 1000; p++) rand_pkt();
    drain();
    compare_words("rand_stall");
    ready_mode = 0;
    pld_stall  = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
